// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : riscv_ctrl_pkg                                             |
// | Brief   : Shared encodings for the multicycle RV32I control FSM:     |
// |           state enum, opcodes, ALUOp, mux selects, ALU controls.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWRITE = 4'd4,
    MEMWB    = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  localparam logic [1:0] C_SRCA_PC    = 2'b00;
  localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] C_SRCA_RS1   = 2'b10;

  localparam logic [1:0] C_SRCB_RS2   = 2'b00;
  localparam logic [1:0] C_SRCB_IMM   = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR  = 2'b10;

  localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] C_RES_DATA      = 2'b01;
  localparam logic [1:0] C_RES_ALURESULT = 2'b10;

  localparam logic [1:0] C_IMM_I = 2'b00;
  localparam logic [1:0] C_IMM_S = 2'b01;
  localparam logic [1:0] C_IMM_B = 2'b10;
  localparam logic [1:0] C_IMM_J = 2'b11;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_OR  = 3'b011;
  localparam logic [2:0] C_ALU_SLT = 3'b101;

  // Immediate format chosen purely from the opcode; unknown opcodes use I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      C_OP_STORE:  imm_src_of = C_IMM_S;
      C_OP_BRANCH: imm_src_of = C_IMM_B;
      C_OP_JAL:    imm_src_of = C_IMM_J;
      default:     imm_src_of = C_IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : multicycle_ctrl_fsm_if                                   |
// | Brief     : Controller <-> datapath/memory bundle. master = control  |
// |             FSM side, slave = datapath side.                         |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control,
           instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control,
           instr_done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_decoder                                                 |
// | Brief  : Maps ALUOp plus funct fields to the 3-bit ALU control code. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  // Fixed add/sub for address and branch work; funct-driven for EXEC states.
  always_comb begin
    o_alu_control = C_ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = C_ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // addi never subtracts: instr[30] is immediate data there
          3'b000:  o_alu_control = (i_funct7b5 & i_op5) ? C_ALU_SUB : C_ALU_ADD;
          3'b010:  o_alu_control = C_ALU_SLT;
          3'b110:  o_alu_control = C_ALU_OR;
          3'b111:  o_alu_control = C_ALU_AND;
          default: o_alu_control = C_ALU_ADD;
        endcase
      end
      default: o_alu_control = C_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : multicycle_ctrl_fsm                                         |
// | Brief  : Multicycle RV32I control sequencer. Walks instructions      |
// |          through fetch/decode/execute/writeback, stalls on the       |
// |          memory req/ready handshake, traps on unknown opcodes.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_ctrl_fsm_if.master       bus
);

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_reg_write;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_res_src;
  logic       w_done;
  logic       w_illegal;
  aluop_t     w_alu_op;
  logic [2:0] w_alu_control;

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_adr_src   = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_reg_write = 1'b0;
    w_src_a     = C_SRCA_PC;
    w_src_b     = C_SRCB_RS2;
    w_res_src   = C_RES_ALUOUT;
    w_done      = 1'b0;
    w_illegal   = 1'b0;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      FETCH: begin
        w_mem_req = 1'b1;
        w_src_b   = C_SRCB_FOUR;
        w_res_src = C_RES_ALURESULT;
        if (bus.mem_ready) begin
          w_ir_write  = 1'b1;
          w_pc_update = 1'b1;
          w_next      = DECODE;
        end
      end
      DECODE: begin
        // Precompute the branch target into ALUOut
        w_src_a = C_SRCA_OLDPC;
        w_src_b = C_SRCB_IMM;
        case (bus.op)
          C_OP_LOAD, C_OP_STORE: w_next = MEMADR;
          C_OP_RTYPE:            w_next = EXECR;
          C_OP_ITYPE:            w_next = EXECI;
          C_OP_BRANCH:           w_next = BEQ;
          C_OP_JAL:              w_next = JAL;
          default:               w_next = TRAP;
        endcase
      end
      MEMADR: begin
        w_src_a = C_SRCA_RS1;
        w_src_b = C_SRCB_IMM;
        w_next  = (bus.op == C_OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_next = MEMWB;
      end
      MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (bus.mem_ready) begin
          w_done = 1'b1;
          w_next = FETCH;
        end
      end
      MEMWB: begin
        w_res_src   = C_RES_DATA;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = FETCH;
      end
      EXECR: begin
        w_src_a  = C_SRCA_RS1;
        w_src_b  = C_SRCB_RS2;
        w_alu_op = ALUOP_FUNCT;
        w_next   = ALUWB;
      end
      EXECI: begin
        w_src_a  = C_SRCA_RS1;
        w_src_b  = C_SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next   = ALUWB;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = FETCH;
      end
      BEQ: begin
        w_src_a  = C_SRCA_RS1;
        w_src_b  = C_SRCB_RS2;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
        w_done   = 1'b1;
        w_next   = FETCH;
      end
      JAL: begin
        // Jump target (from DECODE) goes to PC while PC+4 heads to rd
        w_src_a     = C_SRCA_OLDPC;
        w_src_b     = C_SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = ALUWB;
      end
      TRAP: begin
        w_illegal = 1'b1;
        w_next    = TRAP;
      end
      default: w_next = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .i_op5         (bus.op[5]),
    .o_alu_control (w_alu_control)
  );

  // Outputs are forced quiet while reset is held so nothing escapes mid-reset.
  assign bus.mem_req     = rst_n & w_mem_req;
  assign bus.mem_write   = rst_n & w_mem_write;
  assign bus.adr_src     = rst_n & w_adr_src;
  assign bus.ir_write    = rst_n & w_ir_write;
  assign bus.pc_write    = rst_n & (w_pc_update | (w_branch & bus.zero));
  assign bus.reg_write   = rst_n & w_reg_write;
  assign bus.instr_done  = rst_n & w_done;
  assign bus.illegal     = rst_n & w_illegal;
  assign bus.alu_src_a   = rst_n ? w_src_a       : 2'b00;
  assign bus.alu_src_b   = rst_n ? w_src_b       : 2'b00;
  assign bus.result_src  = rst_n ? w_res_src     : 2'b00;
  assign bus.imm_src     = rst_n ? imm_src_of(bus.op) : 2'b00;
  assign bus.alu_control = rst_n ? w_alu_control : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_multicycle_ctrl_fsm                                      |
// | Brief  : Directed bench; instruction-level model builds the expected |
// |          per-cycle control vectors, one process compares them.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       done;
    logic       illegal;
  } exp_t;

  typedef struct {
    exp_t  e;
    logic  rdy;
    string lbl;
  } step_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   neg_cnt = 0;
  int   done_at = -1;
  logic [2:0] seen_alu;
  step_t cmp_q[$];

  multicycle_ctrl_fsm_if bus_if ();

  multicycle_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == SW)      return 2'b01;
    else if (op == BR) return 2'b10;
    else if (op == JL) return 2'b11;
    else               return 2'b00;
  endfunction

  // ALU function requested by an R/I instruction.
  function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t quiet(input logic [6:0] op);
    exp_t e;
    e = '0;
    e.imm = imm_of(op);
    return e;
  endfunction

  // Single compare process: checks every cycle that has an expectation queued.
  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (bus_if.instr_done) done_at = neg_cnt;
      if (cmp_q.size() > 0) begin
        step_t c;
        exp_t  got;
        c   = cmp_q.pop_front();
        got = {bus_if.mem_req, bus_if.mem_write, bus_if.adr_src, bus_if.ir_write,
               bus_if.pc_write, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b,
               bus_if.result_src, bus_if.imm_src, bus_if.alu_control,
               bus_if.instr_done, bus_if.illegal};
        tests++;
        if (got !== c.e) begin
          fails++;
          $display("FAIL %s @%0t: got %b required %b", c.lbl, $time, got, c.e);
        end
        if (c.lbl == "EXEC") seen_alu = got.alu;
      end
    end
  end

  task automatic push(input exp_t e, input string lbl);
    step_t s;
    s.e = e; s.rdy = 1'b0; s.lbl = lbl;
    cmp_q.push_back(s);
  endtask

  task automatic check(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      push('0, "RST");
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  // Build the expected cycle sequence of one instruction, then play it.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fstall, input int mstall,
                           input int stop, input int trap_n);
    step_t st[$];
    step_t s;
    bus_if.op = op; bus_if.funct3 = f3; bus_if.funct7b5 = f7; bus_if.zero = z;
    done_at  = -1;
    seen_alu = 3'bxxx;
    // fetch, possibly waiting on memory
    for (int i = 0; i <= fstall; i++) begin
      s.e = quiet(op); s.e.mem_req = 1; s.e.b = 2'b10; s.e.res = 2'b10;
      s.rdy = (i == fstall); s.lbl = "FETCH";
      if (s.rdy) begin s.e.ir_write = 1; s.e.pc_write = 1; end
      st.push_back(s);
    end
    s.e = quiet(op); s.e.a = 2'b01; s.e.b = 2'b01; s.rdy = 1; s.lbl = "DECODE";
    st.push_back(s);
    if (op == LW || op == SW) begin
      s.e = quiet(op); s.e.a = 2'b10; s.e.b = 2'b01; s.rdy = 1; s.lbl = "ADDR";
      st.push_back(s);
      for (int i = 0; i <= mstall; i++) begin
        s.e = quiet(op); s.e.mem_req = 1; s.e.adr_src = 1; s.e.mem_write = (op == SW);
        s.rdy = (i == mstall); s.lbl = "MEM";
        if (s.rdy && op == SW) s.e.done = 1;
        st.push_back(s);
      end
      if (op == LW) begin
        s.e = quiet(op); s.e.res = 2'b01; s.e.reg_write = 1; s.e.done = 1;
        s.rdy = 1; s.lbl = "LOADWB";
        st.push_back(s);
      end
    end else if (op == RT || op == IT) begin
      s.e = quiet(op); s.e.a = 2'b10; s.e.b = (op == IT) ? 2'b01 : 2'b00;
      s.e.alu = alu_of(op, f3, f7); s.rdy = 1; s.lbl = "EXEC";
      st.push_back(s);
      s.e = quiet(op); s.e.reg_write = 1; s.e.done = 1; s.rdy = 1; s.lbl = "WB";
      st.push_back(s);
    end else if (op == BR) begin
      s.e = quiet(op); s.e.a = 2'b10; s.e.alu = 3'b001; s.e.pc_write = z;
      s.e.done = 1; s.rdy = 1; s.lbl = "BRANCH";
      st.push_back(s);
    end else if (op == JL) begin
      s.e = quiet(op); s.e.a = 2'b01; s.e.b = 2'b10; s.e.pc_write = 1;
      s.rdy = 1; s.lbl = "JUMP";
      st.push_back(s);
      s.e = quiet(op); s.e.reg_write = 1; s.e.done = 1; s.rdy = 1; s.lbl = "WB";
      st.push_back(s);
    end else begin
      for (int i = 0; i < trap_n; i++) begin
        s.e = quiet(op); s.e.illegal = 1; s.rdy = 1'($urandom_range(0, 1));
        s.lbl = "TRAP";
        st.push_back(s);
      end
    end
    for (int i = 0; i < st.size(); i++) begin
      if (stop >= 0 && i >= stop) break;
      bus_if.mem_ready = st[i].rdy;
      cmp_q.push_back(st[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic instr_lat(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int fstall, input int mstall,
                           input int lat);
    int start;
    start = neg_cnt;
    run_instr(op, f3, f7, z, fstall, mstall, -1, 0);
    check(name, done_at - start, lat);
  endtask

  initial begin
    bus_if.op = BR; bus_if.funct3 = 3'b000; bus_if.funct7b5 = 1'b1;
    bus_if.zero = 1'b1; bus_if.mem_ready = 1'b1;
    @(posedge clk); #1;
    do_reset(3);

    instr_lat("add_lat", RT, 3'b000, 1'b0, 1'b0, 0, 0, 4);
    check("add_alu", int'(seen_alu), 0);
    instr_lat("lw_stall_lat", LW, 3'b010, 1'b0, 1'b0, 0, 2, 7);
    instr_lat("sw_fetchstall_lat", SW, 3'b010, 1'b0, 1'b0, 1, 0, 5);
    instr_lat("beq_taken_lat", BR, 3'b000, 1'b0, 1'b1, 0, 0, 3);
    instr_lat("beq_not_lat", BR, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    instr_lat("sub_lat", RT, 3'b000, 1'b1, 1'b0, 0, 0, 4);
    check("sub_alu", int'(seen_alu), 1);
    instr_lat("addi_b30_lat", IT, 3'b000, 1'b1, 1'b0, 0, 0, 4);
    check("addi_alu", int'(seen_alu), 0);
    instr_lat("slt_lat", RT, 3'b010, 1'b0, 1'b0, 0, 0, 4);
    check("slt_alu", int'(seen_alu), 5);
    instr_lat("and_lat", RT, 3'b111, 1'b0, 1'b0, 0, 0, 4);
    check("and_alu", int'(seen_alu), 2);
    instr_lat("ori_lat", IT, 3'b110, 1'b0, 1'b0, 0, 0, 4);
    check("ori_alu", int'(seen_alu), 3);
    instr_lat("jal_lat", JL, 3'b000, 1'b0, 1'b0, 0, 0, 4);

    // Illegal opcode: absorbing trap until a reset pulse.
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, -1, 20);
    check("trap_illegal", int'(bus_if.illegal), 1);
    do_reset(2);
    instr_lat("post_trap_add_lat", RT, 3'b000, 1'b0, 1'b0, 0, 0, 4);

    // Reset while a store waits on memory: requests must drop at once.
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 10, 6, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_memreq_drop", int'(bus_if.mem_req), 0);
    check("rst_memwrite_drop", int'(bus_if.mem_write), 0);
    do_reset(2);
    instr_lat("post_rst_add_lat", RT, 3'b000, 1'b0, 1'b0, 0, 0, 4);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
